// File: rtl/mem_arb_pkg.sv
// Shared types and master identifiers for the two-master mem_space arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ABORT
  } arb_state_t;

  localparam logic MASTER_INSTR = 1'b0;
  localparam logic MASTER_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags expiry
// on the cycle the count reaches TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0 disables it.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  // Saturating counter: holds at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = (TIMEOUT_CYCLES > 0) && en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_space_arbiter.sv
// Two-master Wishbone-classic arbiter (instruction fetch m0, data m1) in front of mem_space.
// Define MEM_ARB_DATA_PRIORITY_EN to always grant m1 on a tie instead of round-robin.
module mem_space_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_data_i
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       tie_pick;
  logic       req0, req1;
  logic       own_cyc, own_stb, own_we;
  logic [31:0] own_addr, own_data;
  logic [3:0] own_sel;
  logic       busy, expired;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign own_cyc  = (owner_q == MASTER_DATA) ? m1_cyc_i  : m0_cyc_i;
  assign own_stb  = (owner_q == MASTER_DATA) ? m1_stb_i  : m0_stb_i;
  assign own_we   = (owner_q == MASTER_DATA) ? m1_we_i   : m0_we_i;
  assign own_addr = (owner_q == MASTER_DATA) ? m1_addr_i : m0_addr_i;
  assign own_data = (owner_q == MASTER_DATA) ? m1_data_i : m0_data_i;
  assign own_sel  = (owner_q == MASTER_DATA) ? m1_sel_i  : m0_sel_i;

  assign busy = (state_q == ARB_BUSY);

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (~busy | mem_ack_i | mem_err_i),
    .en_i      (busy & own_stb & ~mem_ack_i & ~mem_err_i),
    .expired_o (expired)
  );

`ifdef MEM_ARB_DATA_PRIORITY_EN
  assign tie_pick = MASTER_DATA;
`else
  logic last_q, last_d;
  assign tie_pick = ~last_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      owner_q <= MASTER_INSTR;
`ifndef MEM_ARB_DATA_PRIORITY_EN
      last_q  <= MASTER_DATA;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifndef MEM_ARB_DATA_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifndef MEM_ARB_DATA_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          state_d = ARB_BUSY;
          owner_d = (req0 && req1) ? tie_pick : (req1 ? MASTER_DATA : MASTER_INSTR);
        end
      end
      ARB_BUSY, ARB_ABORT: begin
        // Releasing cyc ends the tenure even after an abort; only BUSY can time out.
        if (!own_cyc) begin
          state_d = ARB_IDLE;
`ifndef MEM_ARB_DATA_PRIORITY_EN
          last_d  = owner_q;
`endif
        end else if (busy && expired) begin
          state_d = ARB_ABORT;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    mem_cyc_o  = 1'b0;
    mem_stb_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_sel_o  = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_data_o  = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_data_o  = '0;
    if (busy) begin
      mem_cyc_o  = own_cyc & ~expired;
      mem_stb_o  = own_stb & ~expired;
      mem_we_o   = own_we;
      mem_addr_o = own_addr;
      mem_data_o = own_data;
      mem_sel_o  = own_sel;
      // A simultaneous slave err overrides ack.
      if (owner_q == MASTER_DATA) begin
        m1_ack_o  = mem_ack_i & ~mem_err_i;
        m1_err_o  = mem_err_i | expired;
        m1_data_o = mem_data_i;
      end else begin
        m0_ack_o  = mem_ack_i & ~mem_err_i;
        m0_err_o  = mem_err_i | expired;
        m0_data_o = mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_space_arbiter.sv
// Self-checking bench for mem_space_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level ownership model.
module tb_mem_space_arbiter;

  localparam int TO = 16;
`ifdef MEM_ARB_DATA_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic [1:0]  ack_o, err_o;
  logic [31:0] rdat_o [2];
  logic        mem_cyc, mem_stb, mem_we;
  logic [31:0] mem_addr, mem_wdat;
  logic [3:0]  mem_sel;
  logic        s_ack, s_err;
  logic [31:0] s_rdat;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who owns the port (-1 = nobody), whether the tenure was aborted,
  // stalled strobe cycles so far, and which master was served last.
  int own;
  bit aborted;
  int stall;
  int last;

  always #5 clk = ~clk;

  mem_space_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_data_i(wdat[0]), .m0_sel_i(sel[0]),
    .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_data_o(rdat_o[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_data_i(wdat[1]), .m1_sel_i(sel[1]),
    .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_data_o(rdat_o[1]),
    .mem_cyc_o(mem_cyc), .mem_stb_o(mem_stb), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wdat), .mem_sel_o(mem_sel),
    .mem_ack_i(s_ack), .mem_err_i(s_err), .mem_data_i(s_rdat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; aborted = 1'b0; stall = 0; last = 1;
  endtask

  function automatic bit m_busy();
    return (own >= 0) && !aborted;
  endfunction

  function automatic bit m_timeout();
    int o;
    o = (own < 0) ? 0 : own;
    return m_busy() && (TO > 0) && stb[o] && !s_ack && !s_err && (stall >= TO - 1);
  endfunction

  task automatic eval();
    int o;
    bit b, t;
    #2;
    o = (own < 0) ? 0 : own;
    b = m_busy();
    t = m_timeout();
    chk("mem_cyc", mem_cyc, b && cyc[o] && !t);
    chk("mem_stb", mem_stb, b && stb[o] && !t);
    chk("mem_we", mem_we, b && we[o]);
    chk("mem_addr", mem_addr, b ? addr[o] : 32'h0);
    chk("mem_data", mem_wdat, b ? wdat[o] : 32'h0);
    chk("mem_sel", mem_sel, b ? sel[o] : 4'h0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_ack", i), ack_o[i], b && (own == i) && s_ack && !s_err);
      chk($sformatf("m%0d_err", i), err_o[i], b && (own == i) && (s_err || t));
      chk($sformatf("m%0d_data", i), rdat_o[i], (b && (own == i)) ? s_rdat : 32'h0);
    end
  endtask

  task automatic model_step();
    bit t;
    t = m_timeout();
    if (own < 0) begin
      if (cyc[0] && stb[0] && cyc[1] && stb[1]) own = PRIO ? 1 : 1 - last;
      else if (cyc[0] && stb[0]) own = 0;
      else if (cyc[1] && stb[1]) own = 1;
      stall = 0;
    end else if (!cyc[own]) begin
      last = own; own = -1; aborted = 1'b0; stall = 0;
    end else if (!aborted) begin
      if (t) begin aborted = 1'b1; stall = 0; end
      else if (s_ack || s_err) stall = 0;
      else if (stb[own]) stall++;
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w, input logic [31:0] a);
    cyc[i] = c; stb[i] = s; we[i] = w; addr[i] = a; wdat[i] = a ^ 32'h5A5A_0000; sel[i] = 4'hF;
  endtask

  task automatic clr_inputs();
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    s_ack = 0; s_err = 0; s_rdat = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int acks;
    int dead;
    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    eval();
    chk("reset_mem_cyc", mem_cyc, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone m0 read with a slave answering on the third strobe cycle.
    set_m(0, 1, 1, 0, 32'h0000_1000);
    eval(); chk("t1_latency", mem_cyc, 0); advance();
    eval(); chk("t1_addr", mem_addr, 32'h0000_1000); chk("t1_cyc", mem_cyc, 1); advance();
    eval(); chk("t1_wait_ack", ack_o[0], 0); advance();
    s_ack = 1; s_rdat = 32'hDEAD_BEEF;
    eval();
    chk("t1_ack", ack_o[0], 1); chk("t1_rdata", rdat_o[0], 32'hDEAD_BEEF); chk("t1_m1_ack", ack_o[1], 0);
    advance();
    clr_inputs(); eval(); advance();

    // Two ties: the first straight after reset, the second after the first winner finishes.
    pulse_reset();
    set_m(0, 1, 1, 0, 32'h100); set_m(1, 1, 1, 1, 32'h200);
    eval(); advance();
    eval(); chk("t2_first_tie", mem_addr, PRIO ? 32'h200 : 32'h100);
    s_ack = 1; eval(); advance();
    clr_inputs(); eval(); advance();
    set_m(0, 1, 1, 0, 32'h100); set_m(1, 1, 1, 1, 32'h200);
    eval(); advance();
    eval(); chk("t2_second_tie", mem_addr, 32'h200);
    s_ack = 1; eval(); advance();
    clr_inputs(); eval(); advance();

    // m1 holds cyc over four acked writes while m0 waits.
    set_m(1, 1, 1, 1, 32'h300);
    eval(); advance();
    set_m(0, 1, 1, 0, 32'h400);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      set_m(1, 1, 1, 1, 32'h300 + 32'(4 * i));
      s_ack = 1;
      eval();
      chk("t3_m0_ack", ack_o[0], 0);
      chk("t3_addr", mem_addr, 32'h300 + 32'(4 * i));
      if (ack_o[1]) acks++;
      advance();
    end
    chk("t3_m1_acks", acks, 4);
    set_m(1, 0, 0, 0, 0); s_ack = 0;
    eval(); advance();
    eval(); chk("t3_gap", mem_cyc, 0); advance();
    eval(); chk("t3_m0_granted", mem_addr, 32'h400);
    s_ack = 1; eval(); advance();
    clr_inputs(); eval(); advance();

    // Watchdog abort on a slave that never answers, then a late ack.
    set_m(0, 1, 1, 0, 32'h500);
    eval(); advance();
    for (int k = 1; k <= TO; k++) begin
      eval();
      chk($sformatf("t4_err_c%0d", k), err_o[0], (k == TO) ? 1 : 0);
      chk($sformatf("t4_cyc_c%0d", k), mem_cyc, (k == TO) ? 0 : 1);
      advance();
    end
    s_ack = 1;
    eval(); chk("t4_late_ack", ack_o[0], 0); chk("t4_abort_cyc", mem_cyc, 0); advance();
    clr_inputs(); eval(); advance();

    // Simultaneous ack and err: err wins.
    set_m(1, 1, 1, 0, 32'h600);
    eval(); advance();
    s_ack = 1; s_err = 1;
    eval(); chk("t5_err", err_o[1], 1); chk("t5_ack", ack_o[1], 0); advance();
    clr_inputs(); eval(); advance();

    // Reset in the middle of a tenure, then a tie.
    set_m(0, 1, 1, 0, 32'h700);
    eval(); advance();
    eval(); chk("t6_busy", mem_cyc, 1);
    s_ack = 1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_cyc", mem_cyc, 0); chk("t6_rst_stb", mem_stb, 0); chk("t6_rst_ack", ack_o[0], 0);
    eval();
    rst_n = 1'b1;
    s_ack = 0;
    set_m(1, 1, 1, 0, 32'h800);
    eval(); advance();
    eval(); chk("t6_tie", mem_addr, PRIO ? 32'h800 : 32'h700);
    clr_inputs(); eval(); advance();

    // Randomized traffic with stretches of a silent slave to exercise the watchdog.
    dead = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) begin
          if (dead == 0 && $urandom_range(5) == 0) cyc[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          cyc[i] = 1'b1;
        end
        stb[i]  = cyc[i] && ($urandom_range(3) != 0);
        we[i]   = 1'($urandom_range(1));
        addr[i] = $urandom;
        wdat[i] = $urandom;
        sel[i]  = 4'($urandom_range(15));
      end
      if (dead > 0) begin
        dead--; s_ack = 0; s_err = 0;
      end else begin
        if ($urandom_range(60) == 0) dead = 30;
        s_ack = ($urandom_range(2) == 0);
        s_err = ($urandom_range(15) == 0);
      end
      s_rdat = $urandom;
      eval();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
